// File: rtl/dispatch_stage_pkg.sv
// Shared defines for the dispatch stage: physical-register and ROB geometry,
// the held-entry layout, and small combinational helpers.
package dispatch_stage_pkg;

  localparam int PREG_NUM     = 64;
  localparam int PREG_RANGE   = $clog2(PREG_NUM);
  localparam int ROB_SIZE_LOG = 4;
  localparam int UOP_W        = 32;

  typedef struct packed {
    logic [PREG_RANGE-1:0]   prs1;
    logic [PREG_RANGE-1:0]   prs2;
    logic [PREG_RANGE-1:0]   prd;
    logic                    src1_is_reg;
    logic                    src2_is_reg;
    logic                    need_to_wb;
    logic                    robidx_flag;
    logic [ROB_SIZE_LOG-1:0] robidx;
    logic [UOP_W-1:0]        uop;
    logic                    src1_state;
    logic                    src2_state;
  } held_entry_t;

  function automatic logic [PREG_NUM-1:0] preg_onehot(input logic [PREG_RANGE-1:0] idx);
    preg_onehot = {{(PREG_NUM-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic wb_hit(input logic valid, input logic need_to_wb,
                                  input logic [PREG_RANGE-1:0] prd,
                                  input logic [PREG_RANGE-1:0] preg);
    wb_hit = valid & need_to_wb & (prd == preg);
  endfunction

  // True when the held entry is younger than the flush point (wrap-flag compare).
  function automatic logic flush_kills(input logic flush_flag,
                                       input logic [ROB_SIZE_LOG-1:0] flush_idx,
                                       input logic held_flag,
                                       input logic [ROB_SIZE_LOG-1:0] held_idx);
    flush_kills = (flush_flag ^ held_flag) ^ (flush_idx < held_idx);
  endfunction

endpackage

// File: rtl/dispatch_stage_busy_table.sv
// Busy table: one bit per physical register, one set port, two clear ports and
// two read ports that already see same-cycle clears. Preg 0 is never busy.
module busy_table
  import dispatch_stage_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic [PREG_RANGE-1:0] set_idx,
  input  logic                  clr0_en,
  input  logic [PREG_RANGE-1:0] clr0_idx,
  input  logic                  clr1_en,
  input  logic [PREG_RANGE-1:0] clr1_idx,
  input  logic [PREG_RANGE-1:0] rd0_idx,
  input  logic [PREG_RANGE-1:0] rd1_idx,
  output logic                  rd0_busy,
  output logic                  rd1_busy
);

  logic [PREG_NUM-1:0] busy_r;
  logic [PREG_NUM-1:0] busy_nxt_s;
  logic [PREG_NUM-1:0] set_mask_s;
  logic [PREG_NUM-1:0] clr_mask_s;

  // Next-state: clears first, then the set so a coincident set wins.
  always_comb begin
    set_mask_s = set_en ? preg_onehot(set_idx) : {PREG_NUM{1'b0}};
    clr_mask_s = (clr0_en ? preg_onehot(clr0_idx) : {PREG_NUM{1'b0}})
               | (clr1_en ? preg_onehot(clr1_idx) : {PREG_NUM{1'b0}});
    busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~preg_onehot({PREG_RANGE{1'b0}});
  end

  // Busy bit storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= {PREG_NUM{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign rd0_busy = busy_r[rd0_idx] & ~(clr0_en & (clr0_idx == rd0_idx))
                                    & ~(clr1_en & (clr1_idx == rd0_idx));
  assign rd1_busy = busy_r[rd1_idx] & ~(clr0_en & (clr0_idx == rd1_idx))
                                    & ~(clr1_en & (clr1_idx == rd1_idx));

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: one-entry output register with operand-readiness tracking.
// Optional perf counters are enabled with `define DISPATCH_PERF_CNT_EN.
module dispatch_stage
  import dispatch_stage_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PREG_RANGE-1:0]   in_prs1,
  input  logic [PREG_RANGE-1:0]   in_prs2,
  input  logic [PREG_RANGE-1:0]   in_prd,
  input  logic                    in_src1_is_reg,
  input  logic                    in_src2_is_reg,
  input  logic                    in_need_to_wb,
  input  logic                    in_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] in_robidx,
  input  logic [UOP_W-1:0]        in_uop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PREG_RANGE-1:0]   out_prs1,
  output logic [PREG_RANGE-1:0]   out_prs2,
  output logic [PREG_RANGE-1:0]   out_prd,
  output logic                    out_src1_is_reg,
  output logic                    out_src2_is_reg,
  output logic                    out_need_to_wb,
  output logic                    out_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] out_robidx,
  output logic [UOP_W-1:0]        out_uop,
  output logic                    out_src1_state,
  output logic                    out_src2_state,
  input  logic                    writeback0_valid,
  input  logic                    writeback0_need_to_wb,
  input  logic [PREG_RANGE-1:0]   writeback0_prd,
  input  logic                    writeback1_valid,
  input  logic                    writeback1_need_to_wb,
  input  logic [PREG_RANGE-1:0]   writeback1_prd,
  input  logic                    flush_valid,
  input  logic                    flush_robidx_flag,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [31:0]             perf_dispatched,
  output logic [31:0]             perf_stall,
`endif
  input  logic [ROB_SIZE_LOG-1:0] flush_robidx
);

  held_entry_t held_r;
  held_entry_t held_nxt_s;
  logic        valid_r;
  logic        valid_nxt_s;
  logic        accept_s;
  logic        transfer_s;
  logic        flush_drop_s;
  logic        rd0_busy_s;
  logic        rd1_busy_s;

  assign in_ready     = ~valid_r | out_ready;
  assign accept_s     = in_valid & in_ready & ~flush_valid;
  assign transfer_s   = valid_r & out_ready;
  assign flush_drop_s = flush_valid & valid_r
                      & flush_kills(flush_robidx_flag, flush_robidx, held_r.robidx_flag, held_r.robidx);

  busy_table u_busy_table (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_en   (accept_s & in_need_to_wb & (in_prd != {PREG_RANGE{1'b0}})),
    .set_idx  (in_prd),
    .clr0_en  (writeback0_valid & writeback0_need_to_wb),
    .clr0_idx (writeback0_prd),
    .clr1_en  (writeback1_valid & writeback1_need_to_wb),
    .clr1_idx (writeback1_prd),
    .rd0_idx  (in_prs1),
    .rd1_idx  (in_prs2),
    .rd0_busy (rd0_busy_s),
    .rd1_busy (rd1_busy_s)
  );

  // Output-register next state: load, drain, flush-drop, or hold with wakeup.
  always_comb begin
    held_nxt_s  = held_r;
    valid_nxt_s = valid_r;
    if (accept_s) begin
      valid_nxt_s            = 1'b1;
      held_nxt_s.prs1        = in_prs1;
      held_nxt_s.prs2        = in_prs2;
      held_nxt_s.prd         = in_prd;
      held_nxt_s.src1_is_reg = in_src1_is_reg;
      held_nxt_s.src2_is_reg = in_src2_is_reg;
      held_nxt_s.need_to_wb  = in_need_to_wb;
      held_nxt_s.robidx_flag = in_robidx_flag;
      held_nxt_s.robidx      = in_robidx;
      held_nxt_s.uop         = in_uop;
      held_nxt_s.src1_state  = in_src1_is_reg & rd0_busy_s;
      held_nxt_s.src2_state  = in_src2_is_reg & rd1_busy_s;
    end else if (transfer_s) begin
      valid_nxt_s = 1'b0;
    end else if (flush_drop_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      held_nxt_s.src1_state = held_r.src1_state & ~(held_r.src1_is_reg
        & (wb_hit(writeback0_valid, writeback0_need_to_wb, writeback0_prd, held_r.prs1)
         | wb_hit(writeback1_valid, writeback1_need_to_wb, writeback1_prd, held_r.prs1)));
      held_nxt_s.src2_state = held_r.src2_state & ~(held_r.src2_is_reg
        & (wb_hit(writeback0_valid, writeback0_need_to_wb, writeback0_prd, held_r.prs2)
         | wb_hit(writeback1_valid, writeback1_need_to_wb, writeback1_prd, held_r.prs2)));
    end
  end

  // Output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      held_r  <= '{default: '0};
    end else begin
      valid_r <= valid_nxt_s;
      held_r  <= held_nxt_s;
    end
  end

  assign out_valid       = valid_r;
  assign out_prs1        = held_r.prs1;
  assign out_prs2        = held_r.prs2;
  assign out_prd         = held_r.prd;
  assign out_src1_is_reg = held_r.src1_is_reg;
  assign out_src2_is_reg = held_r.src2_is_reg;
  assign out_need_to_wb  = held_r.need_to_wb;
  assign out_robidx_flag = held_r.robidx_flag;
  assign out_robidx      = held_r.robidx;
  assign out_uop         = held_r.uop;
  assign out_src1_state  = held_r.src1_state;
  assign out_src2_state  = held_r.src2_state;

`ifdef DISPATCH_PERF_CNT_EN
  // Free-running, wrapping event counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_dispatched <= 32'd0;
      perf_stall      <= 32'd0;
    end else begin
      perf_dispatched <= perf_dispatched + {31'd0, transfer_s};
      perf_stall      <= perf_stall + {31'd0, valid_r & ~out_ready};
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// Self-checking bench for dispatch_stage: directed scenarios, then random traffic
// compared against a cycle-level behavioural model of the dispatch rules.
module tb_dispatch_stage;
  import dispatch_stage_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    in_valid, in_ready;
  logic [PREG_RANGE-1:0]   in_prs1, in_prs2, in_prd;
  logic                    in_src1_is_reg, in_src2_is_reg, in_need_to_wb, in_robidx_flag;
  logic [ROB_SIZE_LOG-1:0] in_robidx;
  logic [UOP_W-1:0]        in_uop;
  logic                    out_valid, out_ready;
  logic [PREG_RANGE-1:0]   out_prs1, out_prs2, out_prd;
  logic                    out_src1_is_reg, out_src2_is_reg, out_need_to_wb, out_robidx_flag;
  logic [ROB_SIZE_LOG-1:0] out_robidx;
  logic [UOP_W-1:0]        out_uop;
  logic                    out_src1_state, out_src2_state;
  logic                    wb0_valid, wb0_need, wb1_valid, wb1_need;
  logic [PREG_RANGE-1:0]   wb0_prd, wb1_prd;
  logic                    flush_valid, flush_flag;
  logic [ROB_SIZE_LOG-1:0] flush_idx;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0]             perf_dispatched, perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [PREG_RANGE-1:0]   prs1, prs2, prd;
    logic                    r1, r2, nwb, flag;
    logic [ROB_SIZE_LOG-1:0] idx;
    logic [UOP_W-1:0]        uop;
    logic                    s1, s2;
  } ment_t;

  bit          m_valid;
  ment_t       m_ent;
  bit          m_busy [PREG_NUM];
  int unsigned m_disp, m_stall;

  dispatch_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_prs1(in_prs1), .in_prs2(in_prs2), .in_prd(in_prd),
    .in_src1_is_reg(in_src1_is_reg), .in_src2_is_reg(in_src2_is_reg),
    .in_need_to_wb(in_need_to_wb), .in_robidx_flag(in_robidx_flag),
    .in_robidx(in_robidx), .in_uop(in_uop), .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_src1_is_reg(out_src1_is_reg), .out_src2_is_reg(out_src2_is_reg),
    .out_need_to_wb(out_need_to_wb), .out_robidx_flag(out_robidx_flag),
    .out_robidx(out_robidx), .out_uop(out_uop),
    .out_src1_state(out_src1_state), .out_src2_state(out_src2_state),
    .writeback0_valid(wb0_valid), .writeback0_need_to_wb(wb0_need), .writeback0_prd(wb0_prd),
    .writeback1_valid(wb1_valid), .writeback1_need_to_wb(wb1_need), .writeback1_prd(wb1_prd),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_flag),
`ifdef DISPATCH_PERF_CNT_EN
    .perf_dispatched(perf_dispatched), .perf_stall(perf_stall),
`endif
    .flush_robidx(flush_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_wb(input int p);
    return (wb0_valid && wb0_need && int'(wb0_prd) == p) ||
           (wb1_valid && wb1_need && int'(wb1_prd) == p);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_disp  = 0;
    m_stall = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_prs1 = '0; in_prs2 = '0; in_prd = '0;
    in_src1_is_reg = 1'b0; in_src2_is_reg = 1'b0; in_need_to_wb = 1'b0;
    in_robidx_flag = 1'b0; in_robidx = '0; in_uop = '0;
    wb0_valid = 1'b0; wb0_need = 1'b0; wb0_prd = '0;
    wb1_valid = 1'b0; wb1_need = 1'b0; wb1_prd = '0;
    flush_valid = 1'b0; flush_flag = 1'b0; flush_idx = '0;
    out_ready = 1'b1;
  endtask

  task automatic put(input int p1, input int p2, input int pd, input bit r1, input bit r2,
                     input bit nwb, input bit flag, input int idx);
    in_valid = 1'b1; in_prs1 = PREG_RANGE'(p1); in_prs2 = PREG_RANGE'(p2);
    in_prd = PREG_RANGE'(pd); in_src1_is_reg = r1; in_src2_is_reg = r2;
    in_need_to_wb = nwb; in_robidx_flag = flag; in_robidx = ROB_SIZE_LOG'(idx);
    in_uop = $urandom;
  endtask

  // One clock: check in_ready, advance the model, then check registered outputs.
  task automatic tick(input string tag);
    bit    rdy, acc, hold;
    bit    nb [PREG_NUM];
    ment_t ne;
    bit    nv;
    #1;
    rdy = !m_valid || out_ready;
    chk({tag, "/in_ready"}, 64'(in_ready), 64'(rdy));
    acc = in_valid && rdy && !flush_valid;
    nb = m_busy;
    if (wb0_valid && wb0_need) nb[wb0_prd] = 1'b0;
    if (wb1_valid && wb1_need) nb[wb1_prd] = 1'b0;
    if (acc && in_need_to_wb && in_prd != 0) nb[in_prd] = 1'b1;
    ne = m_ent;
    nv = m_valid;
    hold = 1'b0;
    if (acc) begin
      nv = 1'b1;
      ne = '{in_prs1, in_prs2, in_prd, in_src1_is_reg, in_src2_is_reg, in_need_to_wb,
             in_robidx_flag, in_robidx, in_uop,
             in_src1_is_reg && in_prs1 != 0 && m_busy[in_prs1] && !m_wb(int'(in_prs1)),
             in_src2_is_reg && in_prs2 != 0 && m_busy[in_prs2] && !m_wb(int'(in_prs2))};
    end else if (m_valid && out_ready) begin
      nv = 1'b0;
    end else if (m_valid && flush_valid &&
                 ((flush_flag != m_ent.flag) != (flush_idx < m_ent.idx))) begin
      nv = 1'b0;
    end else begin
      hold = m_valid;
    end
    if (hold && m_ent.r1 && m_wb(int'(m_ent.prs1))) ne.s1 = 1'b0;
    if (hold && m_ent.r2 && m_wb(int'(m_ent.prs2))) ne.s2 = 1'b0;
    if (m_valid && out_ready) m_disp++;
    if (m_valid && !out_ready) m_stall++;
    @(posedge clock);
    #1;
    m_busy = nb; m_ent = ne; m_valid = nv;
    chk({tag, "/out_valid"}, 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk({tag, "/src1_state"}, 64'(out_src1_state), 64'(m_ent.s1));
      chk({tag, "/src2_state"}, 64'(out_src2_state), 64'(m_ent.s2));
      chk({tag, "/fields"},
          64'({out_prs1, out_prs2, out_prd, out_src1_is_reg, out_src2_is_reg,
               out_need_to_wb, out_robidx_flag, out_robidx}),
          64'({m_ent.prs1, m_ent.prs2, m_ent.prd, m_ent.r1, m_ent.r2,
               m_ent.nwb, m_ent.flag, m_ent.idx}));
      chk({tag, "/uop"}, 64'(out_uop), 64'(m_ent.uop));
    end
`ifdef DISPATCH_PERF_CNT_EN
    chk({tag, "/perf_dispatched"}, 64'(perf_dispatched), 64'(m_disp));
    chk({tag, "/perf_stall"}, 64'(perf_stall), 64'(m_stall));
`endif
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset/out_valid", 64'(out_valid), 64'd0);
    chk("reset/src_states", 64'({out_src1_state, out_src2_state}), 64'd0);
    reset_n = 1'b1;

    // Basic accept: prs1=5, prs2=0, prd=9.
    put(5, 0, 9, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    tick("acc_basic");
    chk("acc_basic/states", 64'({out_src1_state, out_src2_state}), 64'd0);
    // busy[9] visible to a later reader.
    put(9, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    tick("busy9");
    chk("busy9/src1", 64'(out_src1_state), 64'd1);
    // Same-cycle writeback bypass on prs1=9.
    put(9, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    wb0_valid = 1'b1; wb0_need = 1'b1; wb0_prd = 9;
    tick("wb_bypass");
    chk("wb_bypass/src1", 64'(out_src1_state), 64'd0);
    idle();

    // Held wakeup with stall counting.
    put(0, 0, 20, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    tick("set20");
    put(20, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    tick("load20");
    chk("load20/src1", 64'(out_src1_state), 64'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick("stall");
    wb1_valid = 1'b1; wb1_need = 1'b1; wb1_prd = 20;
    tick("held_wake");
    chk("held_wake/src1", 64'(out_src1_state), 64'd0);
    chk("held_wake/valid", 64'(out_valid), 64'd1);
    idle();
    tick("drain");

    // Flush age compare: equal idx kept, older flush point drops.
    put(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
    tick("load6");
    idle(); out_ready = 1'b0;
    flush_valid = 1'b1; flush_flag = 1'b0; flush_idx = 6;
    tick("flush_eq");
    chk("flush_eq/kept", 64'(out_valid), 64'd1);
    flush_idx = 3;
    tick("flush_old");
    chk("flush_old/drop", 64'(out_valid), 64'd0);
    idle();

    // Set wins over clear; flush blocks accept and busy set.
    put(0, 0, 12, 1'b0, 1'b0, 1'b1, 1'b0, 7);
    wb0_valid = 1'b1; wb0_need = 1'b1; wb0_prd = 12;
    tick("set_wins");
    idle();
    put(12, 0, 13, 1'b1, 1'b0, 1'b1, 1'b0, 8);
    flush_valid = 1'b1; flush_flag = 1'b1; flush_idx = 0;
    tick("flush_in");
    chk("flush_in/not_loaded", 64'(out_valid), 64'd0);
    idle();
    put(12, 13, 0, 1'b1, 1'b1, 1'b0, 1'b0, 9);
    tick("after_flush");
    chk("after_flush/states", 64'({out_src1_state, out_src2_state}), 64'b10);
    idle();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_prs1 = PREG_RANGE'($urandom_range(0, 15));
      in_prs2 = PREG_RANGE'($urandom_range(0, 15));
      in_prd = PREG_RANGE'($urandom_range(0, 15));
      in_src1_is_reg = 1'($urandom); in_src2_is_reg = 1'($urandom);
      in_need_to_wb = 1'($urandom); in_robidx_flag = 1'($urandom);
      in_robidx = ROB_SIZE_LOG'($urandom); in_uop = $urandom;
      wb0_valid = 1'($urandom); wb0_need = 1'($urandom); wb0_prd = PREG_RANGE'($urandom_range(0, 15));
      wb1_valid = 1'($urandom); wb1_need = 1'($urandom); wb1_prd = PREG_RANGE'($urandom_range(0, 15));
      flush_valid = ($urandom_range(0, 7) == 0);
      flush_flag = 1'($urandom); flush_idx = ROB_SIZE_LOG'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      tick("rand");
    end
    idle();

    // Asynchronous reset while an entry is held; busy table must also clear.
    put(0, 0, 7, 1'b0, 1'b0, 1'b1, 1'b0, 10);
    tick("pre_reset");
    reset_n = 1'b0;
    #1;
    chk("async_reset/out_valid", 64'(out_valid), 64'd0);
    chk("async_reset/states", 64'({out_src1_state, out_src2_state}), 64'd0);
    model_reset();
    #2 reset_n = 1'b1;
    idle();
    put(7, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 11);
    tick("post_reset");
    chk("post_reset/src1", 64'(out_src1_state), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dispatch_stage.md
DISPATCH_STAGE -- requirements
Module: dispatch_stage

Interface
REQ-001 SHALL have ports: clock  in  1  clock; reset_n  in  1  reset (asynchronous, active-low).
REQ-002 SHALL have: in_valid  in  1; in_ready  out  1  renamed-instr handshake.
REQ-003 SHALL have: in_prs1, in_prs2, in_prd  in  PREG_RANGE; in_src1_is_reg, in_src2_is_reg, in_need_to_wb  in  1.
REQ-004 SHALL have: in_robidx_flag  in  1; in_robidx  in  ROB_SIZE_LOG; in_uop  in  UOP_W  opaque payload (pc, imm, types).
REQ-005 SHALL have: out_valid  out  1; out_ready  in  1 (issue-queue enq_ready); out_* mirrors of every in_* field.
REQ-006 SHALL have: out_src1_state, out_src2_state  out  1  (1 = operand waiting, 0 = ready).
REQ-007 SHALL have: writeback0/1_valid, writeback0/1_need_to_wb  in  1; writeback0/1_prd  in  PREG_RANGE.
REQ-008 SHALL have: flush_valid  in  1; flush_robidx_flag  in  1; flush_robidx  in  ROB_SIZE_LOG.

Function
REQ-009 SHALL keep a PREG_NUM-bit busy table; bit set = result pending.
REQ-010 SHALL hold one instruction in an output register; in_ready = ~out_valid | out_ready (combinational).
REQ-011 Accept = in_valid & in_ready & ~flush_valid; the instruction appears on out_* the next cycle (latency 1).
REQ-012 At accept, srcN_state = srcN_is_reg & busy[prsN] & ~(wb0 hit on prsN) & ~(wb1 hit on prsN); hit = valid & need_to_wb & prd match.
REQ-013 SHALL never report preg 0 as busy; srcN_is_reg=0 forces state 0.
REQ-014 At accept with need_to_wb & prd!=0, SHALL set busy[prd] next cycle.
REQ-015 Writeback hit SHALL clear busy[prd] next cycle; simultaneous set and clear of the same preg -> set wins.
REQ-016 While out_valid & ~out_ready, a writeback hit on the held prsN (is_reg=1) SHALL clear held srcN_state next cycle.
REQ-017 Transfer when out_valid & out_ready; the register is then reloaded by a same-cycle accept, else out_valid falls.
REQ-018 Flush SHALL drop the held entry when (flush_robidx_flag ^ held_flag) ^ (flush_robidx < held_robidx); an equal robidx is kept.
REQ-019 During a flush cycle in_valid SHALL be ignored: no busy set, nothing loaded.
REQ-020 Flush SHALL not modify the busy table.

Reset
REQ-021 Reset SHALL clear out_valid, both out_srcN_state, all busy bits and (if enabled) counters; other out_* fields are don't-care.
REQ-022 Reset asserted mid-transfer SHALL discard the held entry immediately (asynchronous).

Configuration
REQ-023 With DISPATCH_PERF_CNT_EN defined, SHALL add outputs perf_dispatched (32 bits, +1 per out transfer) and perf_stall (32 bits, +1 per out_valid & ~out_ready cycle); both wrap at 2^32.
REQ-024 Without DISPATCH_PERF_CNT_EN, those ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-025 PREG_RANGE, PREG_NUM, ROB_SIZE_LOG and UOP_W SHALL live in the shared defines package.
REQ-026 The busy table (two clear ports, one set port, two read ports with bypass) SHALL be sub-module busy_table.

Verification
REQ-027 Reset, then accept prs1=5, prs2=0, prd=9 -> next cycle out_valid=1, src states 0/0; busy[9]=1.
REQ-028 Accept prs1=9 while busy[9]=1, with writeback0 prd=9 in the same cycle -> out_src1_state=0.
REQ-029 Hold with out_ready=0, src1_state=1, then writeback1 prd=prs1 -> src1_state=0 next cycle; out_valid stays 1; perf_stall counts each held cycle.
REQ-030 Held robidx flag=0/idx=6, flush flag=0/idx=3 -> out_valid=0 next cycle; same entry with flush idx=6 -> kept.
REQ-031 Same-cycle accept of prd=12 and writeback prd=12 -> busy[12]=1; flush together with in_valid -> nothing loaded, busy unchanged.
